// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage: memory-op encodings, control-word field positions,
// exception flag indices, FSM states and load sign-extension helpers.
package mips_pkg;

  typedef enum logic [3:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LBU  = 4'd2,
    MEMOP_LH   = 4'd3,
    MEMOP_LHU  = 4'd4,
    MEMOP_LW   = 4'd5,
    MEMOP_SB   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SW   = 4'd8
  } memop_e;

  localparam int CW_MEMOP_LO = 8;
  localparam int CW_MEMOP_HI = 11;

  localparam int ICW_OVF  = 2;
  localparam int ICW_ADEL = 3;
  localparam int ICW_ADES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } mem_state_e;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            DREQ;
  logic            DWE;
  logic [DW/8-1:0] DBE;
  logic [AW-1:0]   DADDR;
  logic [DW-1:0]   DWDATA;
  logic [DW-1:0]   DRDATA;
  logic            DREADY;

  modport master (output DREQ, DWE, DBE, DADDR, DWDATA, input DRDATA, DREADY);
  modport slave  (input DREQ, DWE, DBE, DADDR, DWDATA, output DRDATA, DREADY);
endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store lane enables/replication, alignment check and
// little-endian load extraction with sign or zero extension.
module mem_align
  import mips_pkg::*;
(
  input  memop_e      memop,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        is_load,
  output logic        is_store,
  output logic        align_err,
  output logic [31:0] load_data
);

  logic [31:0] shifted_s;
  assign shifted_s = rdata >> {offset, 3'b000};

  // decode the op into lane enables, replicated store data and extracted load data
  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    is_load   = 1'b0;
    is_store  = 1'b0;
    align_err = 1'b0;
    load_data = shifted_s;
    case (memop)
      MEMOP_LB: begin
        is_load   = 1'b1;
        load_data = sext8(shifted_s[7:0]);
      end
      MEMOP_LBU: begin
        is_load   = 1'b1;
        load_data = {24'h000000, shifted_s[7:0]};
      end
      MEMOP_LH: begin
        is_load   = 1'b1;
        align_err = offset[0];
        load_data = sext16(shifted_s[15:0]);
      end
      MEMOP_LHU: begin
        is_load   = 1'b1;
        align_err = offset[0];
        load_data = {16'h0000, shifted_s[15:0]};
      end
      MEMOP_LW: begin
        is_load   = 1'b1;
        align_err = (offset != 2'b00);
      end
      MEMOP_SB: begin
        is_store = 1'b1;
        be       = 4'b0001 << offset;
        wdata    = {4{store_data[7:0]}};
      end
      MEMOP_SH: begin
        is_store  = 1'b1;
        align_err = offset[0];
        be        = 4'b0011 << {offset[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
      end
      MEMOP_SW: begin
        is_store  = 1'b1;
        align_err = (offset != 2'b00);
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: bus handshake FSM, pipeline stall, forwarding to ID and the MEM->WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FLUSH,
  input  logic [31:0] CONTROLW_EXE,
  input  logic [7:0]  INTCONTROLW_EXE,
  input  logic [31:0] MEMPC,
  input  logic [31:0] ALURES,
  input  logic [31:0] MEMDATA,
  input  logic [31:0] MEMHILO,
  input  logic [6:0]  EXEDES,
  input  logic [1:0]  EXEWRITEHILO,
  mem_stage_if.master dbus,
  output logic        MEMSTALL,
  output logic [6:0]  MEMFWDDES,
  output logic [31:0] MEMFWDRES,
  output logic        MEMFWDVALID,
  output logic [6:0]  WBDES,
  output logic [1:0]  WBWRITEHILO,
  output logic [31:0] WBRES,
  output logic [31:0] WBHILO,
  output logic [31:0] WBPC,
  output logic [31:0] CONTROLW_MEM,
  output logic [7:0]  INTCONTROLW_MEM,
  output logic [31:0] BADVADDR
);

  memop_e          memop_s;
  logic [3:0]      be_s;
  logic [31:0]     wdata_s;
  logic [31:0]     load_data_s;
  logic            is_load_s, is_store_s, align_err_s, req_ok_s;
  mem_state_e      state_r, state_nxt_s;
  logic            dreq_s, dwe_s, stall_s;
  logic [DW/8-1:0] dbe_s, req_be_r;
  logic [AW-1:0]   daddr_s, req_addr_r;
  logic [DW-1:0]   dwdata_s, req_wdata_r;
  logic            req_we_r;
  logic [7:0]      icw_s;

  assign memop_s = memop_e'(CONTROLW_EXE[CW_MEMOP_HI:CW_MEMOP_LO]);

  mem_align u_align (
    .memop      (memop_s),
    .offset     (ALURES[1:0]),
    .store_data (MEMDATA),
    .rdata      (dbus.DRDATA),
    .be         (be_s),
    .wdata      (wdata_s),
    .is_load    (is_load_s),
    .is_store   (is_store_s),
    .align_err  (align_err_s),
    .load_data  (load_data_s)
  );

  assign req_ok_s = (is_load_s | is_store_s) & ~align_err_s & ~FLUSH;

  // next state and bus drive; WAIT/DRAIN replay the request captured on entry to WAIT
  always_comb begin
    state_nxt_s = state_r;
    dreq_s      = 1'b0;
    daddr_s     = {ALURES[AW-1:2], 2'b00};
    dbe_s       = be_s;
    dwdata_s    = wdata_s;
    dwe_s       = is_store_s;
    case (state_r)
      ST_IDLE: begin
        dreq_s = req_ok_s;
        if (req_ok_s && !dbus.DREADY) state_nxt_s = ST_WAIT;
        else                          state_nxt_s = ST_IDLE;
      end
      ST_WAIT: begin
        dreq_s   = 1'b1;
        daddr_s  = req_addr_r;
        dbe_s    = req_be_r;
        dwdata_s = req_wdata_r;
        dwe_s    = req_we_r;
        if (dbus.DREADY) state_nxt_s = ST_IDLE;
        else if (FLUSH)  state_nxt_s = ST_DRAIN;
        else             state_nxt_s = ST_WAIT;
      end
      ST_DRAIN: begin
        dreq_s   = 1'b1;
        daddr_s  = req_addr_r;
        dbe_s    = req_be_r;
        dwdata_s = req_wdata_r;
        dwe_s    = req_we_r;
        if (dbus.DREADY) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_DRAIN;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // the asserted reset overrides the combinational request so the bus drops immediately
  assign dbus.DREQ   = dreq_s & reset;
  assign dbus.DWE    = dreq_s & reset & dwe_s;
  assign dbus.DADDR  = daddr_s;
  assign dbus.DBE    = dbe_s;
  assign dbus.DWDATA = dwdata_s;
  assign stall_s     = (dbus.DREQ & ~dbus.DREADY) | (state_r == ST_DRAIN);
  assign MEMSTALL    = stall_s;

  assign MEMFWDDES   = EXEDES;
  assign MEMFWDRES   = ALURES;
  assign MEMFWDVALID = ~is_load_s & (EXEDES != 7'd0);

  // merge address-error flags into the exception word
  always_comb begin
    icw_s           = INTCONTROLW_EXE;
    icw_s[ICW_ADEL] = INTCONTROLW_EXE[ICW_ADEL] | (align_err_s & is_load_s);
    icw_s[ICW_ADES] = INTCONTROLW_EXE[ICW_ADES] | (align_err_s & is_store_s);
  end

  // FSM state register and request capture for the wait states
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      req_addr_r  <= '0;
      req_be_r    <= '0;
      req_wdata_r <= '0;
      req_we_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_IDLE && state_nxt_s == ST_WAIT) begin
        req_addr_r  <= daddr_s;
        req_be_r    <= dbe_s;
        req_wdata_r <= dwdata_s;
        req_we_r    <= dwe_s;
      end
    end
  end

  // MEM->WB pipeline register; stall or flush inserts a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      WBDES           <= 7'd0;
      WBWRITEHILO     <= 2'd0;
      WBRES           <= 32'd0;
      WBHILO          <= 32'd0;
      WBPC            <= 32'd0;
      CONTROLW_MEM    <= 32'd0;
      INTCONTROLW_MEM <= 8'd0;
      BADVADDR        <= 32'd0;
    end else if (stall_s || FLUSH) begin
      WBDES           <= 7'd0;
      WBWRITEHILO     <= 2'd0;
      CONTROLW_MEM    <= 32'd0;
      INTCONTROLW_MEM <= 8'd0;
    end else begin
      WBRES           <= is_load_s ? load_data_s : ALURES;
      WBHILO          <= MEMHILO;
      WBPC            <= MEMPC;
      WBDES           <= align_err_s ? 7'd0 : EXEDES;
      WBWRITEHILO     <= align_err_s ? 2'd0 : EXEWRITEHILO;
      CONTROLW_MEM    <= CONTROLW_EXE;
      INTCONTROLW_MEM <= icw_s;
      if (align_err_s) BADVADDR <= ALURES;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: comb bus outputs checked per step, WB register checked
// against a scoreboard of expected MEM->WB contents.
module tb_mem_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        FLUSH;
  logic [31:0] CONTROLW_EXE;
  logic [7:0]  INTCONTROLW_EXE;
  logic [31:0] MEMPC, ALURES, MEMDATA, MEMHILO;
  logic [6:0]  EXEDES;
  logic [1:0]  EXEWRITEHILO;
  logic        MEMSTALL, MEMFWDVALID;
  logic [6:0]  MEMFWDDES, WBDES;
  logic [31:0] MEMFWDRES, WBRES, WBHILO, WBPC, CONTROLW_MEM, BADVADDR;
  logic [1:0]  WBWRITEHILO;
  logic [7:0]  INTCONTROLW_MEM;

  mem_stage_if #(.AW(32), .DW(32)) dbus ();

  mem_stage dut (
    .clk(clk), .reset(reset), .FLUSH(FLUSH), .CONTROLW_EXE(CONTROLW_EXE),
    .INTCONTROLW_EXE(INTCONTROLW_EXE), .MEMPC(MEMPC), .ALURES(ALURES), .MEMDATA(MEMDATA),
    .MEMHILO(MEMHILO), .EXEDES(EXEDES), .EXEWRITEHILO(EXEWRITEHILO), .dbus(dbus),
    .MEMSTALL(MEMSTALL), .MEMFWDDES(MEMFWDDES), .MEMFWDRES(MEMFWDRES),
    .MEMFWDVALID(MEMFWDVALID), .WBDES(WBDES), .WBWRITEHILO(WBWRITEHILO), .WBRES(WBRES),
    .WBHILO(WBHILO), .WBPC(WBPC), .CONTROLW_MEM(CONTROLW_MEM),
    .INTCONTROLW_MEM(INTCONTROLW_MEM), .BADVADDR(BADVADDR)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          bubble;
    bit          chk_res;
    logic [6:0]  des;
    logic [31:0] res;
    logic [31:0] cw;
    logic [7:0]  icw;
    logic [31:0] pc;
  } sb_entry_t;

  sb_entry_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input memop_e op, input logic [31:0] a, input logic [31:0] md,
                       input logic [6:0] des, input logic fl, input logic rdy,
                       input logic [31:0] rd, input logic [7:0] icw);
    CONTROLW_EXE    = {20'h00000, op, 8'hA5};
    INTCONTROLW_EXE = icw;
    ALURES          = a;
    MEMDATA         = md;
    EXEDES          = des;
    FLUSH           = fl;
    MEMPC           = 32'h0000_1000 + a;
    dbus.DREADY     = rdy;
    dbus.DRDATA     = rd;
  endtask

  task automatic expect_wb(input logic [6:0] des, input logic [31:0] res,
                           input logic [7:0] icw, input bit chk_res);
    sb_entry_t e;
    e.bubble = 1'b0; e.chk_res = chk_res; e.des = des; e.res = res;
    e.cw = CONTROLW_EXE; e.icw = icw; e.pc = MEMPC;
    sb.push_back(e);
  endtask

  task automatic expect_bubble();
    sb_entry_t e;
    e.bubble = 1'b1; e.chk_res = 1'b0; e.des = 7'd0; e.res = 32'd0;
    e.cw = 32'd0; e.icw = 8'd0; e.pc = 32'd0;
    sb.push_back(e);
  endtask

  task automatic tick();
    sb_entry_t e;
    @(posedge clk);
    #2;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_underflow observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("wb_des", {25'd0, WBDES}, {25'd0, e.des});
      chk("wb_cw", CONTROLW_MEM, e.cw);
      chk("wb_icw", {24'd0, INTCONTROLW_MEM}, {24'd0, e.icw});
      if (!e.bubble && e.chk_res) begin
        chk("wb_res", WBRES, e.res);
        chk("wb_pc", WBPC, e.pc);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    MEMHILO = 32'h0; EXEWRITEHILO = 2'b00;
    drive(MEMOP_LW, 32'h100, 32'h0, 7'd5, 1'b0, 1'b0, 32'h0, 8'h00);
    #12;
    chk("rst_dreq", {31'd0, dbus.DREQ}, 32'd0);
    chk("rst_stall", {31'd0, MEMSTALL}, 32'd0);
    chk("rst_wbdes", {25'd0, WBDES}, 32'd0);
    chk("rst_wbres", WBRES, 32'd0);
    chk("rst_cw", CONTROLW_MEM, 32'd0);
    chk("rst_badv", BADVADDR, 32'd0);
    @(posedge clk); #2;
    drive(MEMOP_NONE, 32'h0, 32'h0, 7'd0, 1'b0, 1'b0, 32'h0, 8'h00);
    reset = 1'b1;

    // LW, zero-wait
    drive(MEMOP_LW, 32'h100, 32'h0, 7'd5, 1'b0, 1'b1, 32'hDEADBEEF, 8'h00);
    #1;
    chk("lw_dreq", {31'd0, dbus.DREQ}, 32'd1);
    chk("lw_dbe", {28'd0, dbus.DBE}, 32'hF);
    chk("lw_dwe", {31'd0, dbus.DWE}, 32'd0);
    chk("lw_daddr", dbus.DADDR, 32'h100);
    chk("lw_stall", {31'd0, MEMSTALL}, 32'd0);
    chk("lw_fwdvalid", {31'd0, MEMFWDVALID}, 32'd0);
    expect_wb(7'd5, 32'hDEADBEEF, 8'h00, 1'b1);
    tick();

    // sub-word loads
    drive(MEMOP_LB, 32'h103, 32'h0, 7'd6, 1'b0, 1'b1, 32'h80123456, 8'h00);
    expect_wb(7'd6, 32'hFFFFFF80, 8'h00, 1'b1);
    tick();
    drive(MEMOP_LBU, 32'h103, 32'h0, 7'd6, 1'b0, 1'b1, 32'h80123456, 8'h00);
    expect_wb(7'd6, 32'h00000080, 8'h00, 1'b1);
    tick();
    drive(MEMOP_LH, 32'h102, 32'h0, 7'd7, 1'b0, 1'b1, 32'h80011234, 8'h00);
    expect_wb(7'd7, 32'hFFFF8001, 8'h00, 1'b1);
    tick();
    drive(MEMOP_LHU, 32'h102, 32'h0, 7'd7, 1'b0, 1'b1, 32'h80011234, 8'h00);
    expect_wb(7'd7, 32'h00008001, 8'h00, 1'b1);
    tick();

    // stores
    drive(MEMOP_SH, 32'h202, 32'h1234ABCD, 7'd0, 1'b0, 1'b1, 32'h0, 8'h00);
    #1;
    chk("sh_dbe", {28'd0, dbus.DBE}, 32'hC);
    chk("sh_dwdata", dbus.DWDATA, 32'hABCDABCD);
    chk("sh_dwe", {31'd0, dbus.DWE}, 32'd1);
    chk("sh_daddr", dbus.DADDR, 32'h200);
    expect_wb(7'd0, 32'h202, 8'h00, 1'b1);
    tick();
    drive(MEMOP_SB, 32'h201, 32'h000000EF, 7'd0, 1'b0, 1'b1, 32'h0, 8'h00);
    #1;
    chk("sb_dbe", {28'd0, dbus.DBE}, 32'h2);
    chk("sb_dwdata", dbus.DWDATA, 32'hEFEFEFEF);
    expect_wb(7'd0, 32'h201, 8'h00, 1'b1);
    tick();

    // non-memory op forwards its result
    drive(MEMOP_NONE, 32'h55, 32'h0, 7'd9, 1'b0, 1'b0, 32'h0, 8'h00);
    #1;
    chk("fwd_valid", {31'd0, MEMFWDVALID}, 32'd1);
    chk("fwd_res", MEMFWDRES, 32'h55);
    chk("fwd_des", {25'd0, MEMFWDDES}, 32'd9);
    chk("none_dreq", {31'd0, dbus.DREQ}, 32'd0);
    expect_wb(7'd9, 32'h55, 8'h00, 1'b1);
    tick();

    // LW with three wait cycles
    drive(MEMOP_LW, 32'h300, 32'h0, 7'd7, 1'b0, 1'b0, 32'h0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_stall", {31'd0, MEMSTALL}, 32'd1);
      chk("wait_daddr", dbus.DADDR, 32'h300);
      chk("wait_dreq", {31'd0, dbus.DREQ}, 32'd1);
      expect_bubble();
      tick();
    end
    dbus.DREADY = 1'b1;
    dbus.DRDATA = 32'hCAFEF00D;
    #1;
    chk("wait_done_stall", {31'd0, MEMSTALL}, 32'd0);
    expect_wb(7'd7, 32'hCAFEF00D, 8'h00, 1'b1);
    tick();

    // alignment errors
    drive(MEMOP_LW, 32'h101, 32'h0, 7'd8, 1'b0, 1'b1, 32'h0, 8'h00);
    #1;
    chk("adel_dreq", {31'd0, dbus.DREQ}, 32'd0);
    chk("adel_stall", {31'd0, MEMSTALL}, 32'd0);
    expect_wb(7'd0, 32'h0, 8'h08, 1'b0);
    tick();
    chk("adel_badv", BADVADDR, 32'h101);
    drive(MEMOP_SW, 32'h102, 32'h0, 7'd4, 1'b0, 1'b1, 32'h0, 8'h04);
    #1;
    chk("ades_dreq", {31'd0, dbus.DREQ}, 32'd0);
    expect_wb(7'd0, 32'h0, 8'h14, 1'b0);
    tick();
    chk("ades_badv", BADVADDR, 32'h102);

    // FLUSH during WAIT drains the bus transaction
    drive(MEMOP_LW, 32'h400, 32'h0, 7'd3, 1'b0, 1'b0, 32'h0, 8'h00);
    expect_bubble();
    tick();
    FLUSH = 1'b1;
    #1;
    chk("fl_wait_dreq", {31'd0, dbus.DREQ}, 32'd1);
    expect_bubble();
    tick();
    FLUSH = 1'b0;
    #1;
    chk("drain_dreq", {31'd0, dbus.DREQ}, 32'd1);
    chk("drain_stall", {31'd0, MEMSTALL}, 32'd1);
    chk("drain_daddr", dbus.DADDR, 32'h400);
    expect_bubble();
    tick();
    dbus.DREADY = 1'b1;
    #1;
    chk("drain_rdy_stall", {31'd0, MEMSTALL}, 32'd1);
    chk("drain_rdy_dreq", {31'd0, dbus.DREQ}, 32'd1);
    expect_bubble();
    tick();
    drive(MEMOP_NONE, 32'h77, 32'h0, 7'd0, 1'b0, 1'b0, 32'h0, 8'h00);
    #1;
    chk("post_drain_dreq", {31'd0, dbus.DREQ}, 32'd0);
    expect_wb(7'd0, 32'h77, 8'h00, 1'b1);
    tick();

    // FLUSH in IDLE suppresses the request
    drive(MEMOP_LW, 32'h500, 32'h0, 7'd2, 1'b1, 1'b1, 32'h0, 8'h00);
    #1;
    chk("fl_idle_dreq", {31'd0, dbus.DREQ}, 32'd0);
    expect_bubble();
    tick();

    // reset while waiting
    drive(MEMOP_LW, 32'h600, 32'h0, 7'd2, 1'b0, 1'b0, 32'h0, 8'h00);
    expect_bubble();
    tick();
    chk("pre_rst_dreq", {31'd0, dbus.DREQ}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_dreq", {31'd0, dbus.DREQ}, 32'd0);
    chk("mid_rst_stall", {31'd0, MEMSTALL}, 32'd0);
    chk("mid_rst_wbres", WBRES, 32'd0);
    chk("mid_rst_badv", BADVADDR, 32'd0);
    chk("mid_rst_wbpc", WBPC, 32'd0);
    drive(MEMOP_NONE, 32'h88, 32'h0, 7'd0, 1'b0, 1'b0, 32'h0, 8'h00);
    reset = 1'b1;
    expect_wb(7'd0, 32'h88, 8'h00, 1'b1);
    tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
